// File: rtl/ddr3_prbs_tester_if.sv
// User-side DDR3 application port: write-data push and read-data request/return.
interface ddr3_prbs_tester_if;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        rd_en;
    logic [15:0] rd_data;

    modport master (output wr_en, wr_data, rd_en, input rd_data);
    modport slave  (input wr_en, wr_data, rd_en, output rd_data);
endinterface

// File: rtl/ddr3_prbs_tester.sv
// PRBS write/readback tester for the DDR3 user port: writes NUM_WORDS LFSR words,
// waits for the flush, reads them back, compares, and repeats with a per-pass seed.
module ddr3_prbs_tester #(
    parameter logic [27:0] NUM_WORDS = 28'd5120,
    parameter logic [15:0] WAIT_CYC  = 16'd2000,
    parameter logic [1:0]  RD_LAT    = 2'd1,
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter logic [15:0] ERR_MAX   = 16'hFFFF
) (
    input  logic                       i_clk_50m,
    input  logic                       i_rst,
    input  logic                       i_ddr3_init_done,
    ddr3_prbs_tester_if.master         io_app,
    output logic                       o_error_flag,
    output logic [15:0]                o_err_cnt,
    output logic [27:0]                o_first_err_idx,
    output logic [15:0]                o_pass_cnt,
    output logic                       o_busy
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam int unsigned LAT = {30'd0, RD_LAT};

    function automatic logic [15:0] f_lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic [15:0] f_seed(input logic [15:0] pc);
        logic [15:0] s;
        s = SEED ^ pc;
        return (s == '0) ? 16'hACE1 : s;
    endfunction

    logic           r_init_meta, r_init_sync;
    logic [2:0]     r_state;
    logic [27:0]    r_idx, r_cmp_idx, r_first_err_idx;
    logic [15:0]    r_wait_cnt;
    logic [1:0]     r_drain_cnt;
    logic [15:0]    r_gen_lfsr, r_chk_lfsr;
    logic [LAT-1:0] r_rd_pipe;
    logic           r_wr_en, r_rd_en, r_error_flag;
    logic [15:0]    r_wr_data, r_err_cnt, r_pass_cnt;

    logic [LAT-1:0] w_pipe_next;
    logic           w_abort, w_cmp_fire, w_mismatch;
    logic [15:0]    w_pass_seed;

    always_comb begin
        w_pipe_next    = '0;
        w_pipe_next[0] = r_rd_en;
        for (int unsigned i = 1; i < LAT; i++) begin
            w_pipe_next[i] = r_rd_pipe[i-1];
        end
    end

    // DONE already belongs to the next pass, so its seed comes from the incremented count
    assign w_pass_seed = f_seed((r_state == S_DONE) ? r_pass_cnt + 16'd1 : r_pass_cnt);
    assign w_abort     = !r_init_sync && (r_state != S_IDLE);
    assign w_cmp_fire  = r_rd_pipe[LAT-1] && !w_abort;
    assign w_mismatch  = w_cmp_fire && (io_app.rd_data != r_chk_lfsr);

    always_ff @(posedge i_clk_50m or posedge i_rst) begin
        if (i_rst) begin
            r_init_meta     <= 1'b0;
            r_init_sync     <= 1'b0;
            r_state         <= S_IDLE;
            r_idx           <= '0;
            r_cmp_idx       <= '0;
            r_first_err_idx <= '0;
            r_wait_cnt      <= '0;
            r_drain_cnt     <= '0;
            r_gen_lfsr      <= SEED;
            r_chk_lfsr      <= SEED;
            r_rd_pipe       <= '0;
            r_wr_en         <= 1'b0;
            r_rd_en         <= 1'b0;
            r_wr_data       <= '0;
            r_error_flag    <= 1'b0;
            r_err_cnt       <= '0;
            r_pass_cnt      <= '0;
        end else begin
            r_init_meta <= i_ddr3_init_done;
            r_init_sync <= r_init_meta;
            r_rd_pipe   <= w_abort ? '0 : w_pipe_next;

            if (w_cmp_fire) begin
                r_chk_lfsr <= f_lfsr_next(r_chk_lfsr);
                r_cmp_idx  <= r_cmp_idx + 28'd1;
            end
            if (w_mismatch) begin
                r_error_flag <= 1'b1;
                if (r_err_cnt != ERR_MAX) r_err_cnt <= r_err_cnt + 16'd1;
                if (r_err_cnt == '0)      r_first_err_idx <= r_cmp_idx;
            end

            if (w_abort) begin
                r_state <= S_IDLE;
                r_wr_en <= 1'b0;
                r_rd_en <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (r_state == S_DONE || r_init_sync) begin
                            if (r_state == S_DONE) r_pass_cnt <= r_pass_cnt + 16'd1;
                            r_state    <= S_WRITE;
                            r_wr_en    <= 1'b1;
                            r_wr_data  <= w_pass_seed;
                            r_gen_lfsr <= f_lfsr_next(w_pass_seed);
                            r_chk_lfsr <= w_pass_seed;
                            r_idx      <= '0;
                            r_cmp_idx  <= '0;
                        end
                    end
                    S_WRITE: begin
                        if (r_idx == NUM_WORDS - 28'd1) begin
                            r_wr_en    <= 1'b0;
                            r_state    <= S_WAIT;
                            r_wait_cnt <= '0;
                        end else begin
                            r_wr_data  <= r_gen_lfsr;
                            r_gen_lfsr <= f_lfsr_next(r_gen_lfsr);
                            r_idx      <= r_idx + 28'd1;
                        end
                    end
                    S_WAIT: begin
                        if (r_wait_cnt == WAIT_CYC - 16'd1) begin
                            r_state <= S_READ;
                            r_rd_en <= 1'b1;
                            r_idx   <= '0;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + 16'd1;
                        end
                    end
                    S_READ: begin
                        if (r_idx == NUM_WORDS - 28'd1) begin
                            r_rd_en     <= 1'b0;
                            r_state     <= S_DRAIN;
                            r_drain_cnt <= '0;
                        end else begin
                            r_idx <= r_idx + 28'd1;
                        end
                    end
                    S_DRAIN: begin
                        if (r_drain_cnt == RD_LAT - 2'd1) r_state <= S_DONE;
                        else                               r_drain_cnt <= r_drain_cnt + 2'd1;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign io_app.wr_en    = r_wr_en;
    assign io_app.wr_data  = r_wr_data;
    assign io_app.rd_en    = r_rd_en;
    assign o_error_flag    = r_error_flag;
    assign o_err_cnt       = r_err_cnt;
    assign o_first_err_idx = r_first_err_idx;
    assign o_pass_cnt      = r_pass_cnt;
    assign o_busy          = (r_state == S_WRITE) || (r_state == S_WAIT) ||
                             (r_state == S_READ)  || (r_state == S_DRAIN);
endmodule
